// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, owner ids, defaults.
package mem_arb_pkg;

    localparam int unsigned DEF_BLOCK_SIZE = 4;
    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam int unsigned DEF_CNT_W      = 8;

    // One-hot FSM encoding.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_RESP  = 4'b1000
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side, memory-side and status signals around the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned BLOCK_SIZE = 4
);
    localparam int unsigned DW = 32 * BLOCK_SIZE;

    // I-cache side
    logic          I_Req;
    logic [31:0]   I_Address;
    logic [DW-1:0] I_Read_data;
    logic          I_Ready;
    // D-cache side
    logic          D_Req;
    logic          D_Write;
    logic [31:0]   D_Address;
    logic [DW-1:0] D_Write_data;
    logic [DW-1:0] D_Read_data;
    logic          D_Ready;
    // data_memory side
    logic [31:0]   Mem_Address;
    logic          Mem_ReadMiss;
    logic          Mem_WriteThrough;
    logic [DW-1:0] Mem_Write_data;
    logic [DW-1:0] Mem_Read_data;
    logic          Mem_ReadReady;
    logic          Mem_WriteReady;
    // status
    logic          Busy;
    logic          Owner;
    logic          Timeout_err;

    // Arbiter view.
    modport slave (
        input  I_Req, I_Address, D_Req, D_Write, D_Address, D_Write_data,
        input  Mem_Read_data, Mem_ReadReady, Mem_WriteReady,
        output I_Read_data, I_Ready, D_Read_data, D_Ready,
        output Mem_Address, Mem_ReadMiss, Mem_WriteThrough, Mem_Write_data,
        output Busy, Owner, Timeout_err
    );

    // Environment view: caches and memory.
    modport master (
        output I_Req, I_Address, D_Req, D_Write, D_Address, D_Write_data,
        output Mem_Read_data, Mem_ReadReady, Mem_WriteReady,
        input  I_Read_data, I_Ready, D_Read_data, D_Ready,
        input  Mem_Address, Mem_ReadMiss, Mem_WriteThrough, Mem_Write_data,
        input  Busy, Owner, Timeout_err
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin pick; bit 0 = I requester, bit 1 = D requester.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       mask_vld_i,
    input  logic       mask_i,
    output logic       gnt_vld_o,
    output logic       gnt_o
);

    logic [1:0] mask_vec;
    logic [1:0] elig;

    // On a tie, the requester not served last wins; otherwise the lone eligible one.
    always_comb begin
        mask_vec = 2'b00;
        if (mask_vld_i) begin
            mask_vec[mask_i] = 1'b1;
        end
        elig      = req_i & ~mask_vec;
        gnt_vld_o = |elig;
        gnt_o     = OWN_I;
        if (&elig) begin
            gnt_o = ~last_i;
        end else if (elig[OWN_D]) begin
            gnt_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the edge-triggered data_memory, with watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input logic          Clk,
    input logic          Rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned DW = 32 * BLOCK_SIZE;

    state_e            state_q;
    logic              owner_q;
    logic              last_q;
    logic              mask_vld_q;
    logic              mask_q;
    logic              is_write_q;
    logic [31:0]       addr_q;
    logic [DW-1:0]     wdata_q;
    logic              rd_miss_q;
    logic              wr_thr_q;
    logic [DW-1:0]     i_data_q;
    logic [DW-1:0]     d_data_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic              tmo_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;

    logic gnt_vld;
    logic gnt_owner;
    logic done;

    rr_arbiter2 u_rr (
        .req_i      ({bus.D_Req, bus.I_Req}),
        .last_i     (last_q),
        .mask_vld_i (mask_vld_q),
        .mask_i     (mask_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_o      (gnt_owner)
    );

    // Only the ready matching the operation counts; the other may be stale.
    assign done = is_write_q ? bus.Mem_WriteReady : bus.Mem_ReadReady;

    // Sequencer FSM with registered outputs, watchdog and datapath latches.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            last_q     <= OWN_I;
            mask_vld_q <= 1'b0;
            mask_q     <= OWN_I;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_miss_q  <= 1'b0;
            wr_thr_q   <= 1'b0;
            i_data_q   <= '0;
            d_data_q   <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            tmo_q      <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            tmo_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    mask_vld_q <= 1'b0;
                    if (gnt_vld) begin
                        owner_q <= gnt_owner;
                        // Strobe registered here so it is high during ISSUE (the 0->1 edge).
                        if (gnt_owner == OWN_D) begin
                            addr_q     <= bus.D_Address;
                            is_write_q <= bus.D_Write;
                            wdata_q    <= bus.D_Write_data;
                            rd_miss_q  <= ~bus.D_Write;
                            wr_thr_q   <= bus.D_Write;
                        end else begin
                            addr_q     <= bus.I_Address;
                            is_write_q <= 1'b0;
                            rd_miss_q  <= 1'b1;
                            wr_thr_q   <= 1'b0;
                        end
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Ready is not looked at here: it may still be left over from before.
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        rd_miss_q <= 1'b0;
                        wr_thr_q  <= 1'b0;
                        if (!is_write_q) begin
                            if (owner_q == OWN_D) begin
                                d_data_q <= bus.Mem_Read_data;
                            end else begin
                                i_data_q <= bus.Mem_Read_data;
                            end
                        end
                        i_ready_q <= (owner_q == OWN_I);
                        d_ready_q <= (owner_q == OWN_D);
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rd_miss_q <= 1'b0;
                        wr_thr_q  <= 1'b0;
                        i_ready_q <= (owner_q == OWN_I);
                        d_ready_q <= (owner_q == OWN_D);
                        tmo_q     <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Mask the just-served owner for one IDLE cycle to cover its Req lag.
                    last_q     <= owner_q;
                    mask_q     <= owner_q;
                    mask_vld_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Mem_Address      = addr_q;
    assign bus.Mem_ReadMiss     = rd_miss_q;
    assign bus.Mem_WriteThrough = wr_thr_q;
    assign bus.Mem_Write_data   = wdata_q;
    assign bus.I_Read_data      = i_data_q;
    assign bus.I_Ready          = i_ready_q;
    assign bus.D_Read_data      = d_data_q;
    assign bus.D_Ready          = d_ready_q;
    assign bus.Busy             = busy_q;
    assign bus.Owner            = owner_q;
    assign bus.Timeout_err      = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of transactions plus corner-case sequences.
module tb_mem_arbiter;

    localparam int unsigned BS      = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int          LAT     = 20;  // model: ready appears 21 cycles after strobe rise

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] data;
        logic         err;
        int           lat;
    } exp_t;

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic         hang;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.BLOCK_SIZE(BS)) bus ();

    mem_arbiter #(
        .BLOCK_SIZE (BS),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (8)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    exp_t         sb[$];
    logic         owner_log[$];
    logic [127:0] exp_mem [64];
    logic [127:0] last_i = '0;
    logic [127:0] last_d = '0;
    int           cyc = 0;
    int           busy_rise_cyc = 0;
    logic         busy_prev = 1'b0;
    int           i_drop = 0;
    int           d_drop = 0;
    logic         wt_prev = 1'b0;
    logic         wt_seen = 1'b0;
    int           wt_low = 0;

    function automatic logic [127:0] pat(input int k);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'hA000_0000 + 32'(k * 16 + j);
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: edge-triggered strobes; ready stays high until the next strobe edge.
    logic [127:0] mem [64];
    logic         prev_rm, prev_wt, m_rd, mem_hang;
    int           mcnt;
    logic [5:0]   m_idx;
    logic [127:0] m_wd;

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem[k]     <= pat(k);
            exp_mem[k] = pat(k);
        end
        prev_rm <= 1'b0;
        prev_wt <= 1'b0;
        m_rd    <= 1'b1;
        mcnt    <= 0;
        m_idx   <= '0;
        m_wd    <= '0;
        bus.Mem_ReadReady  <= 1'b0;
        bus.Mem_WriteReady <= 1'b0;
        bus.Mem_Read_data  <= '0;
    end

    always @(posedge clk) begin
        prev_rm <= bus.Mem_ReadMiss;
        prev_wt <= bus.Mem_WriteThrough;
        if (bus.Mem_ReadMiss && !prev_rm) begin
            bus.Mem_ReadReady  <= 1'b0;
            bus.Mem_WriteReady <= 1'b0;
            mcnt  <= LAT;
            m_rd  <= 1'b1;
            m_idx <= bus.Mem_Address[9:4];
        end else if (bus.Mem_WriteThrough && !prev_wt) begin
            bus.Mem_ReadReady  <= 1'b0;
            bus.Mem_WriteReady <= 1'b0;
            mcnt  <= LAT;
            m_rd  <= 1'b0;
            m_idx <= bus.Mem_Address[9:4];
            m_wd  <= bus.Mem_Write_data;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !mem_hang) begin
                if (m_rd) begin
                    bus.Mem_Read_data <= mem[m_idx];
                    bus.Mem_ReadReady <= 1'b1;
                end else begin
                    mem[m_idx]         <= m_wd;
                    bus.Mem_WriteReady <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: grant checks, completion scoreboard, strobe spacing, requester Req lag.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (i_drop > 0) begin
                i_drop--;
                if (i_drop == 0) bus.I_Req = 1'b0;
            end
            if (d_drop > 0) begin
                d_drop--;
                if (d_drop == 0) bus.D_Req = 1'b0;
            end
            if (bus.Busy && !busy_prev) begin
                busy_rise_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 1, 0);
                end else begin
                    e = sb[0];
                    chk("grant_owner", bus.Owner, e.is_d);
                    chk("grant_addr", bus.Mem_Address, e.addr);
                    chk("grant_strobes", {bus.Mem_ReadMiss, bus.Mem_WriteThrough}, {!e.wr, e.wr});
                    if (e.wr) chk("grant_wdata", bus.Mem_Write_data, e.wdata);
                end
            end
            busy_prev = bus.Busy;
            if (bus.Mem_WriteThrough && !wt_prev) begin
                if (wt_seen) chk("wt_low_gap_ge2", (wt_low >= 2), 1);
                wt_seen = 1'b1;
                wt_low  = 0;
            end else if (!bus.Mem_WriteThrough) begin
                wt_low++;
            end
            wt_prev = bus.Mem_WriteThrough;
            if (bus.I_Ready && bus.D_Ready) chk("both_ready", 1, 0);
            if (bus.I_Ready || bus.D_Ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    owner_log.push_back(bus.Owner);
                    chk("ready_line", bus.D_Ready, e.is_d);
                    chk("timeout_err", bus.Timeout_err, e.err);
                    chk("read_data", e.is_d ? bus.D_Read_data : bus.I_Read_data, e.data);
                    chk("latency", cyc - busy_rise_cyc, e.lat);
                    if (e.is_d) d_drop = 2;
                    else i_drop = 2;
                end
            end else if (bus.Timeout_err) begin
                chk("lone_timeout_err", 1, 0);
            end
        end
    end

    task automatic issue(input logic is_d, input logic wr, input logic [31:0] addr,
                         input logic [127:0] wd, input logic err);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = is_d & wr;
        e.addr  = addr;
        e.wdata = wd;
        e.err   = err;
        e.lat   = err ? int'(TIMEOUT) + 1 : LAT + 2;
        if (err) begin
            e.data = is_d ? last_d : last_i;
        end else if (e.wr) begin
            e.data = last_d;
            exp_mem[addr[9:4]] = wd;
        end else begin
            e.data = exp_mem[addr[9:4]];
            if (is_d) last_d = e.data;
            else last_i = e.data;
        end
        sb.push_back(e);
        if (is_d) begin
            bus.D_Address    = addr;
            bus.D_Write      = wr;
            bus.D_Write_data = wd;
            bus.D_Req        = 1'b1;
        end else begin
            bus.I_Address = addr;
            bus.I_Req     = 1'b1;
        end
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !bus.Busy && !bus.I_Req && !bus.D_Req) ok = 1'b1;
        end
        chk("idle_within_bound", ok, 1);
    endtask

    task automatic wait_busy();
        logic ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (bus.Busy) ok = 1'b1;
        end
        chk("busy_within_bound", ok, 1);
    endtask

    task automatic wait_d_drop();
        logic ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (!bus.D_Req) ok = 1'b1;
        end
        chk("d_drop_within_bound", ok, 1);
    endtask

    function automatic logic [511:0] all_outs();
        return {bus.I_Read_data, bus.D_Read_data, bus.Mem_Write_data, bus.Mem_Address,
                bus.I_Ready, bus.D_Ready, bus.Mem_ReadMiss, bus.Mem_WriteThrough,
                bus.Busy, bus.Owner, bus.Timeout_err};
    endfunction

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h40, 128'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h80, 128'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h00, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h10, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h00, 128'h0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h10, 128'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h40, 128'h0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h80, 128'h0, 1'b0};

        mem_hang         = 1'b0;
        bus.I_Req        = 1'b0;
        bus.I_Address    = '0;
        bus.D_Req        = 1'b0;
        bus.D_Write      = 1'b0;
        bus.D_Address    = '0;
        bus.D_Write_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 0);
        #1;
        rst = 1'b0;

        // Table: one transaction at a time.
        for (int v = 0; v < 8; v++) begin
            mem_hang = vecs[v].hang;
            issue(vecs[v].is_d, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].hang);
            wait_idle();
            mem_hang = 1'b0;
        end

        // Tie: D wins (last served I), then I; owners 1 then 0.
        owner_log.delete();
        issue(1'b1, 1'b0, 32'h80, '0, 1'b0);
        issue(1'b0, 1'b0, 32'h40, '0, 1'b0);
        wait_idle();
        chk("tie_owner_count", owner_log.size(), 2);
        if (owner_log.size() == 2) chk("tie_owner_seq", {owner_log[0], owner_log[1]}, 2'b10);

        // Back-to-back D writes, then read both back.
        issue(1'b1, 1'b1, 32'h00, 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004, 1'b0);
        wait_d_drop();
        issue(1'b1, 1'b1, 32'h10, 128'hBEEF_0001_BEEF_0002_BEEF_0003_BEEF_0004, 1'b0);
        wait_idle();
        issue(1'b1, 1'b0, 32'h00, '0, 1'b0);
        wait_idle();
        issue(1'b0, 1'b0, 32'h10, '0, 1'b0);
        wait_idle();

        // Stale ready: I read finishes, D write granted next while ReadReady still high.
        issue(1'b0, 1'b0, 32'h20, '0, 1'b0);
        wait_busy();
        issue(1'b1, 1'b1, 32'h30, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        wait_idle();
        issue(1'b1, 1'b0, 32'h30, '0, 1'b0);
        wait_idle();

        // Reset during WAIT, then a normal transaction and a fresh tie.
        issue(1'b1, 1'b0, 32'h80, '0, 1'b0);
        wait_busy();
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        i_drop = 0;
        d_drop = 0;
        bus.D_Req = 1'b0;
        bus.I_Req = 1'b0;
        last_i = '0;
        last_d = '0;
        @(posedge clk);
        #1;
        chk("reset_mid_wait_outputs", all_outs(), 0);
        #1;
        rst = 1'b0;
        busy_prev = 1'b0;
        issue(1'b0, 1'b0, 32'h40, '0, 1'b0);
        wait_idle();
        owner_log.delete();
        issue(1'b1, 1'b0, 32'h00, '0, 1'b0);
        issue(1'b0, 1'b0, 32'h80, '0, 1'b0);
        wait_idle();
        if (owner_log.size() == 2) chk("post_reset_tie_seq", {owner_log[0], owner_log[1]}, 2'b10);
        else chk("post_reset_tie_count", owner_log.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
